// File: rtl/mat_trans_pkg.sv
// Shared bank-state type and read-address helper for the ping-pong matrix transposer.
package mat_trans_pkg;

   // Widest counter supported (N = 64).
   localparam int unsigned MaxCw = 12;

   typedef enum logic [1:0] {
      BankEmpty,
      BankFill,
      BankFull,
      BankDrain
   } bank_st_e;

   // Transposed read address: swaps the row and column halves of the element index.
   function automatic logic [MaxCw-1:0] tp_addr(input logic [MaxCw-1:0] k,
                                                input logic              bypass,
                                                input int unsigned       aw);
      logic [MaxCw-1:0] lo;
      logic [MaxCw-1:0] hi;
      lo = k & ((MaxCw'(1) << aw) - MaxCw'(1));
      hi = k >> aw;
      return bypass ? k : ((lo << aw) | hi);
   endfunction

endpackage

// File: rtl/mat_trans_bank.sv
// One matrix bank: N*N flop array, one synchronous write port, one combinational read port.
module mat_trans_bank #(
   parameter int unsigned DW = 32,
   parameter int unsigned N  = 8,
   parameter int unsigned CW = 2 * $clog2(N)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [CW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [CW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [N*N];

   // Contents are deliberately not reset; bank state decides what is meaningful.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mat_trans_pp.sv
// Streaming NxN transposer: row-major in, column-major (or bypassed row-major) out,
// using two banks so one matrix fills while the previous one drains.
module mat_trans_pp
   import mat_trans_pkg::*;
#(
   parameter int unsigned DW = 32,
   parameter int unsigned N  = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          cfg_bypass,
   input  logic          in_vld,
   output logic          in_rdy,
   input  logic [DW-1:0] in_data,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [DW-1:0] out_data,
   output logic          out_sof,
   output logic          out_eof
);

   localparam int unsigned AW = $clog2(N);
   localparam int unsigned CW = 2 * AW;
   localparam logic [CW-1:0] LastIdx = CW'(N * N - 1);

   bank_st_e      st_q [2];
   bank_st_e      st_d [2];
   logic [1:0]    byp_q, byp_d;
   logic [CW-1:0] wr_cnt_q, wr_cnt_d;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d;
   logic          wbank_q, wbank_d;
   logic          rbank_q, rbank_d;
   logic          live_q;

   logic          wr_fire, rd_fire;
   logic          wr_last, rd_last;
   logic [CW-1:0] raddr;
   logic [1:0]    bank_we;
   logic [DW-1:0] rdata [2];

   // Holds in_rdy low until the first clock edge after reset is released.
   assign in_rdy  = live_q & ((st_q[wbank_q] == BankEmpty) | (st_q[wbank_q] == BankFill));
   assign out_vld = (st_q[rbank_q] == BankFull) | (st_q[rbank_q] == BankDrain);

   assign wr_fire = in_vld & in_rdy & ~clr;
   assign rd_fire = out_vld & out_rdy & ~clr;
   assign wr_last = (wr_cnt_q == LastIdx);
   assign rd_last = (rd_cnt_q == LastIdx);

   assign raddr = CW'(tp_addr(MaxCw'(rd_cnt_q), byp_q[rbank_q], AW));

   for (genvar g = 0; g < 2; g++) begin : g_bank
      assign bank_we[g] = wr_fire & (wbank_q == 1'(g));

      mat_trans_bank #(
         .DW (DW),
         .N  (N),
         .CW (CW)
      ) u_bank (
         .clk   (clk),
         .we    (bank_we[g]),
         .waddr (wr_cnt_q),
         .wdata (in_data),
         .raddr (raddr),
         .rdata (rdata[g])
      );
   end

   always_comb begin
      st_d     = st_q;
      byp_d    = byp_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      wbank_d  = wbank_q;
      rbank_d  = rbank_q;

      if (wr_fire) begin
         wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;
         if (wr_last) begin
            wbank_d = ~wbank_q;
         end
      end

      if (rd_fire) begin
         rd_cnt_d = rd_last ? '0 : rd_cnt_q + 1'b1;
         if (rd_last) begin
            rbank_d = ~rbank_q;
         end
      end

      // Write and read never target the same bank, so both transitions can fire together.
      for (int i = 0; i < 2; i++) begin
         unique case (st_q[i])
            BankEmpty: begin
               if (bank_we[i]) begin
                  st_d[i]  = BankFill;
                  byp_d[i] = cfg_bypass;
               end
            end
            BankFill: begin
               if (bank_we[i] && wr_last) begin
                  st_d[i] = BankFull;
               end
            end
            BankFull: begin
               if (rbank_q == 1'(i)) begin
                  st_d[i] = BankDrain;
               end
            end
            BankDrain: begin
               if (rd_fire && rd_last && (rbank_q == 1'(i))) begin
                  st_d[i] = BankEmpty;
               end
            end
            default: st_d[i] = BankEmpty;
         endcase
      end

      if (clr) begin
         st_d     = '{BankEmpty, BankEmpty};
         wr_cnt_d = '0;
         rd_cnt_d = '0;
         wbank_d  = 1'b0;
         rbank_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q     <= '{BankEmpty, BankEmpty};
         byp_q    <= '0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         wbank_q  <= 1'b0;
         rbank_q  <= 1'b0;
         live_q   <= 1'b0;
      end else begin
         st_q     <= st_d;
         byp_q    <= byp_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         wbank_q  <= wbank_d;
         rbank_q  <= rbank_d;
         live_q   <= 1'b1;
      end
   end

   assign out_data = out_vld ? rdata[rbank_q] : '0;
   assign out_sof  = out_vld & (rd_cnt_q == '0);
   assign out_eof  = out_vld & rd_last;

endmodule
